// File: rtl/hex_word_entry_pkg.sv
// Shared definitions for the hex word entry path: FSM encoding and word sizing.
package hex_word_entry_pkg;

    localparam int unsigned NIBBLES_DEF = 4;
    localparam int unsigned WORD_W      = 4 * NIBBLES_DEF;

    // COLLECT assembles nibbles, SEND offers the finished word to the processor.
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_SEND    = 1'b1
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low key, emitting a single-cycle pulse per press.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_pulse
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_prev;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer, stability counter, and falling-edge detect on the stable level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            stable      <= 1'b1;
            stable_prev <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= key_n;
            sync2       <= sync1;
            stable_prev <= stable;
            press_pulse <= stable_prev & ~stable;
            if (sync2 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hex_word_entry.sv
// Builds a word from switch nibbles on debounced ENTER presses and offers it over valid/ready.
module hex_word_entry
    import hex_word_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned NIBBLES         = NIBBLES_DEF,
    localparam int unsigned W              = 4 * NIBBLES,
    localparam int unsigned CNT_W          = $clog2(NIBBLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_enter_n,
    input  logic             key_clear_n,
    input  logic [3:0]       sw_nibble,
    output logic [W-1:0]     din,
    output logic             din_valid,
    input  logic             din_ready,
    output logic [W-1:0]     preview,
    output logic [CNT_W-1:0] nibble_count
);

    logic enter_pulse;
    logic clear_pulse;

    state_t             state_q;
    state_t             state_d;
    logic [W-1:0]       preview_d;
    logic [W-1:0]       din_d;
    logic               din_valid_d;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   count_inc;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_enter_n),
        .press_pulse (enter_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_clear_n),
        .press_pulse (clear_pulse)
    );

    assign count_inc = nibble_count + CNT_W'(1);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_COLLECT;
            preview      <= '0;
            nibble_count <= '0;
            din          <= '0;
            din_valid    <= 1'b0;
        end else begin
            state_q      <= state_d;
            preview      <= preview_d;
            nibble_count <= count_d;
            din          <= din_d;
            din_valid    <= din_valid_d;
        end
    end

    // Next-state logic: clear beats enter; keys are ignored while a word is on offer.
    always_comb begin
        state_d     = state_q;
        preview_d   = preview;
        count_d     = nibble_count;
        din_d       = din;
        din_valid_d = din_valid;
        case (state_q)
            ST_COLLECT: begin
                if (clear_pulse) begin
                    preview_d = '0;
                    count_d   = '0;
                end else if (enter_pulse) begin
                    preview_d = {preview[W-5:0], sw_nibble};
                    count_d   = count_inc;
                    if (count_inc == CNT_W'(NIBBLES)) begin
                        din_d       = preview_d;
                        din_valid_d = 1'b1;
                        state_d     = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (din_valid && din_ready) begin
                    din_valid_d = 1'b0;
                    preview_d   = '0;
                    count_d     = '0;
                    state_d     = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_hex_word_entry.sv
// Self-checking bench for hex_word_entry with a word scoreboard on the valid/ready port.
module tb_hex_word_entry;

    localparam int unsigned DC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_enter_n;
    logic        key_clear_n;
    logic [3:0]  sw_nibble;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] preview;
    logic [2:0]  nibble_count;

    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    int          valid_cycles = 0;
    logic [15:0] exp_q[$];
    logic        hold_ok;

    hex_word_entry #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_enter_n  (key_enter_n),
        .key_clear_n  (key_clear_n),
        .sw_nibble    (sw_nibble),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .preview      (preview),
        .nibble_count (nibble_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive keys low together for the hold time, then release for the same time.
    task automatic press(input logic use_enter, input logic use_clear, input logic [3:0] nib);
        sw_nibble = nib;
        if (use_enter) key_enter_n = 1'b0;
        if (use_clear) key_clear_n = 1'b0;
        repeat (10) tick();
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic enter_level(input logic lvl, input int n);
        key_enter_n = lvl;
        repeat (n) tick();
    endtask

    task automatic hold_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            hold_ok = hold_ok & din_valid;
        end
    endtask

    // Monitor: every accepted transfer is compared with the oldest expected word.
    always @(negedge clk) begin
        if (rst) begin
            if (din_valid) valid_cycles++;
            if (din_valid && din_ready) begin
                xfers++;
                if (exp_q.size() == 0)
                    check_eq("unexpected_xfer", 32'(din_valid && din_ready), 32'd0);
                else
                    check_eq("xfer_din", 32'(din), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int x0;
        int v0;

        rst         = 1'b0;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        sw_nibble   = 4'h0;
        din_ready   = 1'b1;
        repeat (3) tick();
        check_eq("rst_din", 32'(din), 32'd0);
        check_eq("rst_valid", 32'(din_valid), 32'd0);
        check_eq("rst_preview", 32'(preview), 32'd0);
        check_eq("rst_count", 32'(nibble_count), 32'd0);
        rst = 1'b1;
        tick();

        // Clean entry with the processor always ready.
        x0 = xfers;
        v0 = valid_cycles;
        press(1, 0, 4'hA);
        check_eq("clean_prev1", 32'(preview), 32'h000A);
        check_eq("clean_cnt1", 32'(nibble_count), 32'd1);
        press(1, 0, 4'h1);
        press(1, 0, 4'h2);
        check_eq("clean_prev3", 32'(preview), 32'h0A12);
        check_eq("clean_cnt3", 32'(nibble_count), 32'd3);
        exp_q.push_back(16'hA12F);
        press(1, 0, 4'hF);
        check_eq("clean_xfers", 32'(xfers - x0), 32'd1);
        check_eq("clean_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check_eq("clean_valid_low", 32'(din_valid), 32'd0);
        check_eq("clean_prev0", 32'(preview), 32'd0);
        check_eq("clean_cnt0", 32'(nibble_count), 32'd0);

        // Backpressure: word held while not ready, ENTER during the wait ignored.
        din_ready = 1'b0;
        x0 = xfers;
        press(1, 0, 4'h1);
        press(1, 0, 4'h2);
        press(1, 0, 4'h3);
        exp_q.push_back(16'h1234);
        sw_nibble   = 4'h4;
        key_enter_n = 1'b0;
        for (int i = 0; i < 20 && !din_valid; i++) tick();
        check_eq("bp_valid_rise", 32'(din_valid), 32'd1);
        hold_ok = 1'b1;
        hold_ticks(6);
        key_enter_n = 1'b1;
        hold_ticks(10);
        sw_nibble   = 4'h9;
        key_enter_n = 1'b0;
        hold_ticks(10);
        key_enter_n = 1'b1;
        hold_ticks(10);
        check_eq("bp_valid_held", 32'(hold_ok), 32'd1);
        check_eq("bp_din", 32'(din), 32'h1234);
        check_eq("bp_preview", 32'(preview), 32'h1234);
        check_eq("bp_count", 32'(nibble_count), 32'd4);
        check_eq("bp_no_xfer_yet", 32'(xfers - x0), 32'd0);
        din_ready = 1'b1;
        repeat (6) tick();
        check_eq("bp_xfers", 32'(xfers - x0), 32'd1);
        check_eq("bp_valid_low", 32'(din_valid), 32'd0);
        check_eq("bp_count0", 32'(nibble_count), 32'd0);

        // Bounce rejection: short glitches then one real press.
        sw_nibble = 4'h5;
        enter_level(1'b0, 1);
        enter_level(1'b1, 1);
        enter_level(1'b0, 2);
        enter_level(1'b1, 1);
        enter_level(1'b0, 3);
        enter_level(1'b1, 1);
        enter_level(1'b0, 8);
        enter_level(1'b1, 12);
        check_eq("bounce_count", 32'(nibble_count), 32'd1);
        check_eq("bounce_preview", 32'(preview), 32'h0005);

        // Clear discards the partial word; a fresh word then goes through.
        press(1, 0, 4'h7);
        press(1, 0, 4'h8);
        check_eq("clr_pre_preview", 32'(preview), 32'h0578);
        check_eq("clr_pre_count", 32'(nibble_count), 32'd3);
        press(0, 1, 4'h0);
        check_eq("clr_preview", 32'(preview), 32'd0);
        check_eq("clr_count", 32'(nibble_count), 32'd0);
        x0 = xfers;
        press(1, 0, 4'h1);
        press(1, 0, 4'h2);
        press(1, 0, 4'h3);
        exp_q.push_back(16'h1234);
        press(1, 0, 4'h4);
        check_eq("clr_xfers", 32'(xfers - x0), 32'd1);
        check_eq("clr_count_after", 32'(nibble_count), 32'd0);

        // Simultaneous ENTER and CLEAR: clear wins.
        press(1, 0, 4'h3);
        press(1, 0, 4'hC);
        check_eq("sim_pre_preview", 32'(preview), 32'h003C);
        press(1, 1, 4'hE);
        check_eq("sim_preview", 32'(preview), 32'd0);
        check_eq("sim_count", 32'(nibble_count), 32'd0);

        // Reset while a word is on offer discards it.
        din_ready = 1'b0;
        press(1, 0, 4'h1);
        press(1, 0, 4'h2);
        press(1, 0, 4'h3);
        exp_q.push_back(16'h1234);
        press(1, 0, 4'h4);
        check_eq("rs_valid_before", 32'(din_valid), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        check_eq("rs_valid", 32'(din_valid), 32'd0);
        check_eq("rs_din", 32'(din), 32'd0);
        check_eq("rs_count", 32'(nibble_count), 32'd0);
        check_eq("rs_preview", 32'(preview), 32'd0);
        x0 = xfers;
        din_ready = 1'b1;
        repeat (10) tick();
        check_eq("rs_no_xfer", 32'(xfers - x0), 32'd0);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
